// File: rtl/sdspi_bench_reader.sv
// Benchmark sequencer for the SD/SPI host: reads n_blocks blocks, one byte request at a time,
// and keeps a running modulo-2^32 sum of every byte read so the run can be checked.
module sdspi_bench_reader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          BLOCK_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] n_blocks,
    input  logic [4:0]  sclk_speed,
    input  logic        cmd18,
    output logic        finish,
    output logic        error,
    output logic [31:0] checksum,
    output logic [4:0]  host_sclk_speed,
    output logic [31:0] block_addr,
    output logic        r_block,
    output logic        r_multi_block,
    output logic        r_byte,
    input  logic        busy,
    input  logic        err,
    input  logic [7:0]  data_out
);

    localparam logic [31:0] BLOCK_LEN = 32'(BLOCK_BYTES);

    typedef enum logic [3:0] {
        IDLE, LOAD, REQ_BLK, WAIT_BLK, REQ_BYTE, WAIT_BYTE, NEXT_BLK, STOP, DONE, ERROR
    } state_t;

    state_t      state;
    logic [31:0] blk_target;
    logic [31:0] blk_cnt;
    logic [31:0] byte_cnt;
    logic        multi;
    logic        active;

    assign active = (state != IDLE) && (state != DONE) && (state != ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            blk_target      <= '0;
            blk_cnt         <= '0;
            byte_cnt        <= '0;
            multi           <= 1'b0;
            finish          <= 1'b0;
            error           <= 1'b0;
            checksum        <= '0;
            host_sclk_speed <= '0;
            block_addr      <= '0;
            r_block         <= 1'b0;
            r_multi_block   <= 1'b0;
            r_byte          <= 1'b0;
        end else if (!start && state != IDLE) begin
            // Losing start abandons the run from any state, including DONE and ERROR.
            state         <= IDLE;
            blk_cnt       <= '0;
            byte_cnt      <= '0;
            finish        <= 1'b0;
            error         <= 1'b0;
            checksum      <= '0;
            block_addr    <= '0;
            r_block       <= 1'b0;
            r_multi_block <= 1'b0;
            r_byte        <= 1'b0;
        end else if (active && err) begin
            state         <= ERROR;
            finish        <= 1'b1;
            error         <= 1'b1;
            r_block       <= 1'b0;
            r_multi_block <= 1'b0;
            r_byte        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    blk_target      <= n_blocks;
                    multi           <= cmd18;
                    host_sclk_speed <= sclk_speed;
                    checksum        <= '0;
                    blk_cnt         <= '0;
                    byte_cnt        <= '0;
                    block_addr      <= BASE_ADDR;
                    if (n_blocks == 32'd0) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end else begin
                        state         <= REQ_BLK;
                        r_block       <= !cmd18;
                        r_multi_block <= cmd18;
                    end
                end
                REQ_BLK: begin
                    if (busy) state <= WAIT_BLK;
                end
                WAIT_BLK: begin
                    if (!busy) begin
                        state  <= REQ_BYTE;
                        r_byte <= 1'b1;
                    end
                end
                REQ_BYTE: begin
                    if (busy) begin
                        state  <= WAIT_BYTE;
                        r_byte <= 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (!busy) begin
                        checksum <= checksum + {24'd0, data_out};
                        byte_cnt <= byte_cnt + 32'd1;
                        if (byte_cnt + 32'd1 < BLOCK_LEN) begin
                            state  <= REQ_BYTE;
                            r_byte <= 1'b1;
                        end else begin
                            state   <= NEXT_BLK;
                            r_block <= 1'b0;
                        end
                    end
                end
                NEXT_BLK: begin
                    // Single-block reads must let the host finish CMD17 before the next request.
                    if (multi || !busy) begin
                        blk_cnt  <= blk_cnt + 32'd1;
                        byte_cnt <= '0;
                        if (blk_cnt + 32'd1 == blk_target) begin
                            if (multi) begin
                                state         <= STOP;
                                r_multi_block <= 1'b0;
                            end else begin
                                state  <= DONE;
                                finish <= 1'b1;
                            end
                        end else begin
                            state      <= REQ_BLK;
                            block_addr <= multi ? BASE_ADDR : BASE_ADDR + blk_cnt + 32'd1;
                            r_block    <= !multi;
                        end
                    end
                end
                STOP: begin
                    if (!busy) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE, ERROR: begin
                    state <= state;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdspi_bench_reader.sv
// Bench for sdspi_bench_reader: behavioural SD host plus a table of read runs and
// directed sequences for empty runs, host errors, mid-run reset and checksum wrap.
module tb_sdspi_bench_reader;

    localparam logic [31:0] BASE         = 32'hFFFF_FFFF;
    localparam int          BLK          = 512;
    localparam logic [31:0] WRAP_PRELOAD = 32'hFFFE_0200;
    localparam int          NV           = 6;

    typedef struct {
        int          n;
        bit          multi;
        logic [4:0]  speed;
        logic [7:0]  seed;
        bit          ff;
        bit          preload;
        logic [31:0] exp_sum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, cmd18;
    logic [31:0] n_blocks;
    logic [4:0]  sclk_speed;
    logic        finish, error, r_block, r_multi_block, r_byte;
    logic [31:0] checksum, block_addr;
    logic [4:0]  host_sclk_speed;
    logic        busy = 1'b0;
    logic        err = 1'b0;
    logic [7:0]  data_out = 8'd0;

    int n_cmp = 0;
    int n_fail = 0;

    // host model configuration and state
    logic [7:0]  data_seed;
    bit          all_ff;
    int          err_byte;
    int          hop, hcnt, need_token, bidx, blk_bytes;
    bit          in_multi;
    // monitor results
    int          rbyte_rises, rblock_rises, rmulti_rises, stop_cnt;
    bit          both_seen, req_seen, finish_busy_seen, err_resp_checked, err_resp_ok;
    bit          prev_rbyte, prev_rblock, prev_rmulti, prev_finish;
    logic [31:0] addr_q[$];

    vec_t vecs[NV];

    sdspi_bench_reader #(.BASE_ADDR(BASE), .BLOCK_BYTES(BLK)) dut (
        .clk(clk), .rst(rst), .start(start), .n_blocks(n_blocks), .sclk_speed(sclk_speed),
        .cmd18(cmd18), .finish(finish), .error(error), .checksum(checksum),
        .host_sclk_speed(host_sclk_speed), .block_addr(block_addr), .r_block(r_block),
        .r_multi_block(r_multi_block), .r_byte(r_byte), .busy(busy), .err(err),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_rule(input logic [7:0] seed, input bit ff, input int idx);
        logic [31:0] t;
        t = 32'(idx) + {24'd0, seed};
        return ff ? 8'hFF : t[7:0];
    endfunction

    function automatic logic [31:0] model_sum(input vec_t v);
        logic [31:0] s;
        s = v.preload ? WRAP_PRELOAD : 32'd0;
        for (int i = 0; i < v.n * BLK; i++) s = s + {24'd0, byte_rule(v.seed, v.ff, i)};
        return s;
    endfunction

    // Monitor first (sees what the DUT saw at the last rising edge), then the host responds.
    always @(negedge clk) begin
        if (err) begin
            err_resp_checked = 1'b1;
            err_resp_ok = finish && error && !r_block && !r_multi_block && !r_byte;
        end
        err = 1'b0;
        if (r_byte && !prev_rbyte) rbyte_rises++;
        if (r_block && !prev_rblock) rblock_rises++;
        if (r_multi_block && !prev_rmulti) rmulti_rises++;
        if (r_block && r_multi_block) both_seen = 1'b1;
        if (r_block || r_multi_block || r_byte) req_seen = 1'b1;
        if (finish && !prev_finish && busy) finish_busy_seen = 1'b1;
        prev_rbyte = r_byte; prev_rblock = r_block;
        prev_rmulti = r_multi_block; prev_finish = finish;
        if (rst || !start) begin
            busy = 1'b0; hop = 0; hcnt = 0; need_token = 1; in_multi = 1'b0;
            bidx = 0; blk_bytes = 0;
            rbyte_rises = 0; rblock_rises = 0; rmulti_rises = 0; stop_cnt = 0;
            both_seen = 1'b0; req_seen = 1'b0; finish_busy_seen = 1'b0;
            err_resp_checked = 1'b0; err_resp_ok = 1'b0;
            addr_q.delete();
        end else if (busy) begin
            if (hcnt == 0) begin
                busy = 1'b0;
                if (hop == 2) begin
                    data_out = byte_rule(data_seed, all_ff, bidx);
                    bidx++;
                    blk_bytes++;
                    if (blk_bytes == BLK) begin
                        blk_bytes = 0;
                        need_token = 2;
                    end
                end
                hop = 0;
            end else begin
                hcnt--;
            end
        end else if (need_token == 2) begin
            need_token = 1;
        end else if ((r_block || r_multi_block) && need_token == 1) begin
            busy = 1'b1; hop = 1; hcnt = $urandom_range(0, 2); need_token = 0;
            addr_q.push_back(block_addr);
            if (r_multi_block) in_multi = 1'b1;
        end else if (r_byte) begin
            busy = 1'b1; hop = 2; hcnt = $urandom_range(0, 1);
            if (bidx == err_byte) err = 1'b1;
        end else if (in_multi && !r_multi_block) begin
            busy = 1'b1; hop = 3; hcnt = $urandom_range(1, 3);
            in_multi = 1'b0; stop_cnt++;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int n, input bit multi, input logic [4:0] speed,
                                  input logic [7:0] seed, input bit ff);
        @(negedge clk);
        data_seed  = seed;
        all_ff     = ff;
        n_blocks   = 32'(n);
        cmd18      = multi;
        sclk_speed = speed;
        start      = 1'b1;
    endtask

    task automatic wait_finish(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (finish) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        bit ok;
        bit seen;
        apply_stimulus(v.n, v.multi, v.speed, v.seed, v.ff);
        if (v.preload) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (r_block) seen = 1'b1;
            end
            check_output({tag, ".req_seen"}, 32'(seen), 32'd1);
            force dut.checksum = WRAP_PRELOAD;
            @(negedge clk);
            release dut.checksum;
        end
        wait_finish(v.n * 4000 + 100, ok);
        check_output({tag, ".finish"}, 32'(ok), 32'd1);
        check_output({tag, ".checksum"}, checksum, v.exp_sum);
        check_output({tag, ".error"}, 32'(error), 32'd0);
        check_output({tag, ".r_byte_rises"}, 32'(rbyte_rises), 32'(v.n * BLK));
        check_output({tag, ".host_sclk_speed"}, 32'(host_sclk_speed), 32'(v.speed));
        check_output({tag, ".both_requests"}, 32'(both_seen), 32'd0);
        if (v.multi) begin
            check_output({tag, ".r_multi_rises"}, 32'(rmulti_rises), 32'd1);
            check_output({tag, ".r_block_rises"}, 32'(rblock_rises), 32'd0);
            check_output({tag, ".stop_cmds"}, 32'(stop_cnt), 32'd1);
            check_output({tag, ".finish_while_busy"}, 32'(finish_busy_seen), 32'd0);
        end else begin
            check_output({tag, ".r_block_rises"}, 32'(rblock_rises), 32'(v.n));
            check_output({tag, ".r_multi_rises"}, 32'(rmulti_rises), 32'd0);
        end
        check_output({tag, ".addr_count"}, 32'(addr_q.size()), 32'(v.n));
        for (int k = 0; k < addr_q.size() && k < v.n; k++)
            check_output($sformatf("%s.addr%0d", tag, k), addr_q[k],
                         v.multi ? BASE : BASE + 32'(k));
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output({tag, ".idle_finish"}, 32'(finish), 32'd0);
        check_output({tag, ".idle_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        vec_t rv;
        bit   ok;
        bit   found;
        rst = 1'b1; start = 1'b0; n_blocks = '0; cmd18 = 1'b0; sclk_speed = '0;
        err_byte = -1; data_seed = '0; all_ff = 1'b0;

        vecs[0] = '{2, 1'b0, 5'd3,  8'd0, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{3, 1'b1, 5'd17, 8'($urandom), 1'b0, 1'b0, 32'd0};
        vecs[2] = '{1, 1'b0, 5'd1,  8'd0, 1'b1, 1'b1, 32'd0};
        for (int i = 3; i < NV; i++)
            vecs[i] = '{$urandom_range(1, 2), 1'($urandom_range(0, 1)), 5'($urandom),
                        8'($urandom), 1'b0, 1'b0, 32'd0};
        for (int i = 0; i < NV; i++) vecs[i].exp_sum = model_sum(vecs[i]);

        repeat (3) @(negedge clk);
        check_output("reset.finish", 32'(finish), 32'd0);
        check_output("reset.error", 32'(error), 32'd0);
        check_output("reset.checksum", checksum, 32'd0);
        check_output("reset.block_addr", block_addr, 32'd0);
        check_output("reset.requests", {29'd0, r_block, r_multi_block, r_byte}, 32'd0);
        check_output("reset.host_sclk_speed", 32'(host_sclk_speed), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // empty run: LOAD goes straight to DONE
        apply_stimulus(0, 1'b0, 5'd2, 8'd0, 1'b0);
        @(negedge clk);
        check_output("n0.finish_cycle1", 32'(finish), 32'd0);
        @(negedge clk);
        check_output("n0.finish_cycle2", 32'(finish), 32'd1);
        @(negedge clk);
        check_output("n0.requests", 32'(req_seen), 32'd0);
        check_output("n0.error", 32'(error), 32'd0);
        start = 1'b0;
        @(negedge clk);

        // host error during byte 100 of block 0
        err_byte = 100;
        apply_stimulus(2, 1'b0, 5'd5, 8'd0, 1'b0);
        wait_finish(4000, ok);
        check_output("err.finish", 32'(ok), 32'd1);
        check_output("err.next_cycle_seen", 32'(err_resp_checked), 32'd1);
        check_output("err.next_cycle_outputs", 32'(err_resp_ok), 32'd1);
        check_output("err.error", 32'(error), 32'd1);
        check_output("err.requests", {29'd0, r_block, r_multi_block, r_byte}, 32'd0);
        check_output("err.bytes_requested", 32'(rbyte_rises), 32'd101);
        start = 1'b0;
        err_byte = -1;
        @(negedge clk);
        @(negedge clk);
        check_output("err.idle_finish", 32'(finish), 32'd0);
        check_output("err.idle_error", 32'(error), 32'd0);

        // reset while the DUT waits for a byte
        apply_stimulus(1, 1'b0, 5'd4, 8'd9, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 4000 && !found; c++) begin
            @(negedge clk);
            #1;
            if (busy && hop == 2 && r_byte && bidx >= 50) found = 1'b1;
        end
        check_output("rst.reached_byte", 32'(found), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst.finish", 32'(finish), 32'd0);
        check_output("rst.checksum", checksum, 32'd0);
        check_output("rst.block_addr", block_addr, 32'd0);
        check_output("rst.requests", {29'd0, r_block, r_multi_block, r_byte}, 32'd0);
        check_output("rst.host_sclk_speed", 32'(host_sclk_speed), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rv = '{1, 1'b0, 5'd4, 8'd9, 1'b0, 1'b0, 32'd0};
        rv.exp_sum = model_sum(rv);
        run_vector(rv, "rst_rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
